// File: rtl/imem_responder.sv
// imem_responder: RV32I instruction-memory responder with a fixed-latency read pipe and an in-order response FIFO.
// Define IMEM_MISALIGN_TRAP_EN to turn misaligned fetches into NOP responses with rsp_err set.
module imem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    input  logic        flush,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);
    localparam int AW     = $clog2(DEPTH_WORDS);
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam int STAGES = LATENCY - 1;
    localparam logic [31:0]   NOP     = 32'h0000_0013;
    localparam logic [29:0]   DEPTH_W = 30'(DEPTH_WORDS);
    localparam logic [CW-1:0] FIFO_D  = CW'(FIFO_DEPTH);
    localparam logic [PW:0]   PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } rsp_t;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [STAGES:0] vld_pipe;
    rsp_t          stg [LATENCY];
    rsp_t          fifo [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic [CW-1:0] outstanding;
    logic          accept, pop, push, fifo_empty, tail_vld, misalign, oor;
    rsp_t          req_rsp, tail, head;
    logic [29:0]   req_idx, ld_idx;
    logic          unused_ld;

    assign req_idx   = req_addr[31:2];
    assign ld_idx    = ld_addr[31:2];
    assign unused_ld = &{1'b0, ld_addr[1:0]};

`ifdef IMEM_MISALIGN_TRAP_EN
    assign misalign = (req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign oor = (req_idx >= DEPTH_W);

    always_comb begin
        req_rsp.addr  = req_addr;
        req_rsp.err   = oor | misalign;
        req_rsp.instr = NOP;
        if (!(oor | misalign)) req_rsp.instr = mem[req_idx[AW-1:0]];
    end

    // Credits cover pipe + FIFO, so a full count stalls requests before the FIFO can overflow.
    assign req_ready  = !flush && (outstanding < FIFO_D);
    assign accept     = req_valid && req_ready;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign tail_vld   = vld_pipe[STAGES];
    assign tail       = stg[STAGES];

    // The pipe tail is presented directly when the FIFO is empty; if not taken it is
    // pushed and reappears unchanged at the FIFO head next cycle.
    assign rsp_valid = !fifo_empty || tail_vld;
    assign head      = fifo_empty ? tail : fifo[rd_ptr[PW-1:0]];
    assign pop       = rsp_valid && rsp_ready && !flush;
    assign push      = tail_vld && !flush && !(fifo_empty && pop);

    assign rsp_instr = rsp_valid ? head.instr : '0;
    assign rsp_addr  = rsp_valid ? head.addr  : '0;
    assign rsp_err   = rsp_valid ? head.err   : 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else if (flush) begin
            vld_pipe    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            vld_pipe[0] <= accept;
            for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !fifo_empty) rd_ptr <= rd_ptr + PTR_ONE;
            if (accept && !pop) outstanding <= outstanding + CNT_ONE;
            else if (pop && !accept) outstanding <= outstanding - CNT_ONE;
        end
    end

    // Memory write and pipe capture share an edge, so a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (ld_en && (ld_idx < DEPTH_W)) mem[ld_idx[AW-1:0]] <= ld_data;
        stg[0] <= req_rsp;
        for (int k = 1; k <= STAGES; k++) stg[k] <= stg[k-1];
        if (push) fifo[wr_ptr[PW-1:0]] <= tail;
    end
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: table-driven fetches plus hand sequences for backpressure, flush and reset,
// checked through an expected-response queue.
module tb_imem_responder;
    localparam int L = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, rst = 1'b0;
    logic        req_valid = 1'b0, rsp_ready = 1'b0, flush = 1'b0, ld_en = 1'b0;
    logic [31:0] req_addr = '0, ld_addr = '0, ld_data = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_instr, rsp_addr;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(1024), .LATENCY(L), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err), .flush(flush),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
        int          cyc;
        bit          exact;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    exp_t        q[$];
    exp_t        e;
    int          lat;
    int          cyc = 0;
    int          vectors = 0, miscompares = 0;
    logic [31:0] mdl [1024];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every valid response is matched to the oldest expected entry.
    always @(negedge clk) begin
        if (!rst || flush) q.delete();
        else if (rsp_valid) begin
            if (q.size() == 0) chk("unexpected_rsp", rsp_addr, 32'hFFFF_FFFF);
            else begin
                e = q[0];
                lat = cyc - e.cyc;
                chk("rsp_instr", rsp_instr, e.instr);
                chk("rsp_addr", rsp_addr, e.addr);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                if (e.exact) chk("latency_exact", lat, L);
                else chk("latency_min", {31'b0, lat >= L}, 32'd1);
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    // All tasks start and end #1 after a rising edge.
    task automatic send(input logic [31:0] a, input logic [31:0] ei, input logic ee,
                        input bit exact, output bit acc);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        acc = req_ready;
        if (acc) q.push_back('{a, ei, ee, cyc, exact});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        if (a[31:2] < 30'd1024) mdl[a[11:2]] = d;
    endtask

    task automatic wait_empty(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [7];
        bit   acc;
        int   n_acc;

        vecs[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h00A0_0113, 1'b0};
        vecs[2] = '{32'h0000_1000, NOP,           1'b1};
        vecs[3] = '{32'h0000_0FFC, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{32'hFFFF_FFFC, NOP,           1'b1};
        vecs[5] = '{32'h0000_0020, 32'h1000_0020, 1'b0};
`ifdef IMEM_MISALIGN_TRAP_EN
        vecs[6] = '{32'h0000_0002, NOP,           1'b1};
`else
        vecs[6] = '{32'h0000_0002, 32'h0050_0093, 1'b0};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_rsp_valid_post", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_instr", rsp_instr, 32'd0);
        chk("reset_rsp_addr", rsp_addr, 32'd0);
        chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        @(posedge clk); #1;

        // Program load; the write to 0x1000 must be dropped, not alias onto word 0
        load(32'h0, 32'h0050_0093);
        load(32'h4, 32'h00A0_0113);
        for (int i = 2; i < 16; i++) load(32'(i * 4), 32'h1000_0000 + 32'(i * 4));
        load(32'h0000_0FFC, 32'hCAFE_F00D);
        load(32'h0000_1000, 32'hBAD0_BAD0);

        // Back-to-back at exact latency
        rsp_ready = 1'b1;
        send(32'h0, 32'h0050_0093, 1'b0, 1'b1, acc);
        chk("b2b_accept0", {31'b0, acc}, 32'd1);
        send(32'h4, 32'h00A0_0113, 1'b0, 1'b1, acc);
        chk("b2b_accept1", {31'b0, acc}, 32'd1);
        wait_empty("b2b_drain");

        // Table-driven vectors, streamed back-to-back
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].addr, vecs[i].instr, vecs[i].err, 1'b0, acc);
            chk("vec_accept", {31'b0, acc}, 32'd1);
        end
        wait_empty("vec_drain");

        // Read-before-write on the same index
        ld_en = 1'b1; ld_addr = 32'h8; ld_data = 32'h0BAD_F00D;
        send(32'h8, mdl[2], 1'b0, 1'b0, acc);
        ld_en = 1'b0;
        mdl[2] = 32'h0BAD_F00D;
        send(32'h8, 32'h0BAD_F00D, 1'b0, 1'b0, acc);
        wait_empty("rbw_drain");

        // Backpressure: exactly FIFO_DEPTH accepted, head frozen while stalled
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(32'(i * 4), mdl[i], 1'b0, 1'b0, acc);
            if (acc) n_acc++;
        end
        chk("bp_accept_count", 32'(n_acc), 32'd4);
        @(negedge clk);
        chk("bp_req_ready_low", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_drain_valid", {31'b0, rsp_valid}, 32'd1);
        end
        @(negedge clk);
        chk("bp_drained_valid", {31'b0, rsp_valid}, 32'd0);
        chk("bp_req_ready_back", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        wait_empty("bp_queue");

        // Flush with 3 outstanding, together with a request
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'(i * 4), mdl[i], 1'b0, 1'b0, acc);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_000C;
        @(negedge clk);
        chk("flush_req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("flush_next_valid", {31'b0, rsp_valid}, 32'd0);
        chk("flush_next_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        send(32'h10, mdl[4], 1'b0, 1'b1, acc);
        chk("flush_after_accept", {31'b0, acc}, 32'd1);
        wait_empty("flush_drain");
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-stream with 2 responses buffered
        rsp_ready = 1'b0;
        send(32'h0, mdl[0], 1'b0, 1'b0, acc);
        send(32'h4, mdl[1], 1'b0, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pre_valid", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_async_drop", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_no_stale", {31'b0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        send(32'h0, 32'h0050_0093, 1'b0, 1'b1, acc);
        chk("rst_mem_accept", {31'b0, acc}, 32'd1);
        send(32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 1'b0, acc);
        wait_empty("rst_mem_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the RV32I pipeline: it serves the fetch stage's instruction requests over a valid/ready handshake. Each accepted request returns one 32-bit word after a fixed read latency, in request order. Responses are buffered in a response FIFO. A flush from branch resolution discards every in-flight and buffered response. A load port writes program words into the memory.

## Interface
- DEPTH_WORDS, 1024 — memory size in 32-bit words; power of 2.
- LATENCY, 2 — cycles from request acceptance to earliest rsp_valid; 1..4.
- FIFO_DEPTH, 4 — response FIFO entries; power of 2; must be >= LATENCY+1.
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  request can be accepted this cycle.
- req_addr  input  32  byte address of the instruction.
- rsp_valid  output  1  FIFO head holds a response.
- rsp_ready  input  1  fetch consumes the response.
- rsp_instr  output  32  instruction word.
- rsp_addr  output  32  byte address echoed from the request.
- rsp_err  output  1  request was out of range or misaligned.
- flush  input  1  discard all outstanding work (taken branch).
- ld_en  input  1  write enable for the load port.
- ld_addr  input  32  byte address for the load write; bits [1:0] are ignored.
- ld_data  input  32  word to write.

## Operation
- **Accept:** a request is accepted when req_valid && req_ready. On acceptance the word index req_addr[31:2] is captured and the memory is read.
- **Read pipe:** a LATENCY-stage pipe carries {valid, addr, instr, err}. Each stage's valid bit is reset. The final stage pushes into the FIFO.
- **Credit counter:** outstanding = in-pipe + FIFO occupancy.
  - Width is clog2(FIFO_DEPTH)+1.
  - Increment on accept; decrement on pop.
  - Accept and pop in the same cycle leave it unchanged.
- **req_ready:** equals !flush && (outstanding < FIFO_DEPTH). It ignores a same-cycle pop, so it is independent of rsp_ready. The FIFO therefore never overflows.
- **Pop:** occurs on rsp_valid && rsp_ready. FIFO pointers wrap modulo FIFO_DEPTH.
- **Out of range:** if the word index is >= DEPTH_WORDS, the response is rsp_instr=0x00000013 (NOP) with rsp_err=1.
- **Flush:** in the flush cycle, all pipe valids, FIFO pointers and the credit counter clear at the next edge. No request is accepted that cycle. A pop presented in the same cycle is ignored.
- **Load port:** when ld_en is high, mem[ld_addr[31:2]] <= ld_data. Writes to out-of-range addresses are dropped. A same-cycle read of the same index returns the old word (read-before-write).
- **Reset:** the memory array is not reset. Load writes are not gated by the handshake.

## Timing
- **Reset values:** req_ready=1 (after deassertion), rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0. Pipe and FIFO are emptied and outstanding=0.
- **Latency:** a request accepted at the end of cycle t gives rsp_valid in cycle t+LATENCY if the FIFO was empty. A response never arrives earlier.
- **Throughput:** with rsp_ready held high, one response per cycle is sustained indefinitely.
- **rsp_* stability:** all rsp_* outputs are held stable while rsp_valid && !rsp_ready.
- **Reset mid-operation:** asserting rst drops rsp_valid immediately (asynchronously). Pending responses are lost. No response is produced after release.
- **Flush recovery:** the cycle after flush has rsp_valid=0 and req_ready=1.

## Configuration
- **IMEM_MISALIGN_TRAP_EN defined:**
  - If req_addr[1:0] != 0, the response is NOP 0x00000013 with rsp_err=1.
  - The memory is not read for that request.
  - rsp_addr carries the unmodified address.
- **IMEM_MISALIGN_TRAP_EN undefined:**
  - req_addr[1:0] is ignored and the aligned word is returned.
  - rsp_err reflects out-of-range only.

## Test plan
- **Back-to-back:**
  - Stimulus: load 0x00500093 at 0x0 and 0x00A00113 at 0x4 (defaults). Hold rsp_ready=1 and request 0x0, then 0x4, in consecutive cycles.
  - Required response: rsp_valid in cycles t+2 and t+3, with rsp_instr 0x00500093 then 0x00A00113, in order.
- **Backpressure:**
  - Stimulus: hold rsp_ready=0 and stream requests.
  - Required response: exactly 4 are accepted, then req_ready=0. rsp_* outputs stay frozen.
  - On release, the 4 responses drain in order, one per cycle, and req_ready returns to 1.
- **Flush:**
  - Stimulus: with 3 responses outstanding, pulse flush together with req_valid.
  - Required response: that request is not accepted, no stale response ever appears, and the next request's response arrives at the normal latency.
- **Out of range:**
  - Stimulus: request address 0x00001000 (index 1024).
  - Required response: rsp_instr=0x00000013, rsp_err=1, rsp_addr=0x00001000.
- **Misaligned, macro on:**
  - Stimulus: request 0x00000002.
  - Required response: NOP with rsp_err=1.
- **Misaligned, macro off:**
  - Stimulus: request 0x00000002.
  - Required response: word 0x00500093 with rsp_err=0.
- **Reset mid-stream:**
  - Stimulus: assert rst with 2 responses buffered.
  - Required response: rsp_valid falls immediately. After release, no response appears and loaded memory contents are intact.
